md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencer for the iterative multiply/divide unit in the EXE stage.
- Accepts mult/multu/div/divu/mthi/mtlo from EXE and launches the unit.
- Counts the fixed latency of the operation, then commits the result to the architectural HI/LO registers it owns.
- Raises the pipeline stall that holds dependent MD ops and mfhi/mflo reads until the result is committed.

Parameters:
- MULT_LAT, 5, cycles from accept to HI/LO commit for mult/multu (must be at least 1).
- DIV_LAT, 33, cycles from accept to HI/LO commit for div/divu (must be at least 1).
- CNT_W, 6, width of the latency counter (must hold max(MULT_LAT, DIV_LAT)-1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- op_valid  in  1  an MD op is present in EXE
- op_code  in  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; any other value is no-op
- src_a  in  32  forwarded rs value
- src_b  in  32  forwarded rt value
- flush  in  1  kill the op in EXE and any op in flight
- rd_hi  in  1  mfhi in EXE
- rd_lo  in  1  mflo in EXE
- md_start  out  1  one-cycle launch pulse to the unit
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu
- md_a  out  32  registered operand A
- md_b  out  32  registered operand B
- md_hi  in  32  unit HI result, valid in the final RUN cycle
- md_lo  in  32  unit LO result, valid in the final RUN cycle
- stall  out  1  freeze IF/ID/EXE
- hi_rdata  out  32  HI value for mfhi
- lo_rdata  out  32  LO value for mflo
- hilo_we  out  1  one-cycle pulse after any HI/LO commit
- div_zero  out  1  one-cycle pulse when a divide by zero is rejected

Behaviour:
- Reset values: all outputs 0; hi_q = lo_q = 0; state = IDLE; counter = 0.
- States: IDLE, RUN.
- Accept condition: state == IDLE and op_valid and !flush. An op present while stalled is not accepted until the state is IDLE.
- mult/multu accepted:
  - At the accept edge, latch md_a = src_a, md_b = src_b and md_op; set cnt = MULT_LAT-1; go to RUN.
  - md_start = 1 in the first RUN cycle only.
- div/divu accepted:
  - Same as mult, with cnt = DIV_LAT-1.
  - If src_b == 0, do not launch: stay in IDLE, leave HI/LO unchanged, pulse div_zero in the next cycle.
- mthi/mtlo accepted: write src_a into hi_q or lo_q at the accept edge; pulse hilo_we in the next cycle; stay in IDLE.
- RUN state:
  - cnt decrements each cycle.
  - In the cycle with cnt == 0, capture md_hi into hi_q and md_lo into lo_q at the clock edge, return to IDLE, and pulse hilo_we in the next cycle.
  - Latency: the accept edge plus LAT edges to HI/LO visibility, i.e. the new hi_q appears LAT cycles after accept.
- stall = (state == RUN) and (op_valid or rd_hi or rd_lo). No stall in IDLE, because HI/LO are already current.
- flush in RUN: return to IDLE at the next edge with no commit, no hilo_we pulse and HI/LO unchanged. The unit's in-flight result is ignored.
- flush in IDLE: the op in EXE is not accepted.
- Reset mid-RUN: return to IDLE immediately; HI/LO cleared.
- An op arriving on the same cycle as the cnt == 0 commit is stalled for that cycle and accepted in the following IDLE cycle.
- hi_rdata = hi_q and lo_rdata = lo_q.

Optional Feature:
- Macro: MD_BYPASS_EN.
- Defined:
  - In a RUN cycle with cnt == 0, hi_rdata = md_hi and lo_rdata = md_lo.
  - rd_hi/rd_lo do not raise stall in that cycle, which saves one cycle for back-to-back mfhi.
  - op_valid still stalls in that cycle.
- Undefined: behaviour exactly as in Behaviour.

Decomposition:
- Shared package (md_pkg): op_code encodings, md_op encodings, state enum, default latencies.
- One sub-module: md_lat_cnt, a loadable down-counter with a zero flag. The FSM and HI/LO registers stay in md_sched.

Test Plan:
- Signed product: mult, src_a = 7, src_b = 0xFFFFFFFD; bench unit model returns its result at cnt == 0.
  - Response: stall for 5 cycles while op_valid is held; hi_q = 0xFFFFFFFF, lo_q = 0xFFFFFFEB; hilo_we pulses once.
- Quotient/remainder with read interlock: divu 100 / 7, then mflo held in EXE.
  - Response: stall held for 33 cycles; lo_rdata = 14, hi_rdata = 2 in the first IDLE cycle.
- Divide by zero: div, src_b = 0, with HI = 0x1234 beforehand.
  - Response: no md_start; div_zero pulses once; HI stays 0x1234; stall never asserted.
- Flush in flight: mult 3 × 4, then flush at cycle 2 of RUN.
  - Response: return to IDLE; HI/LO keep their prior values; no hilo_we.
- Back-to-back: mthi 0xDEAD immediately followed by mult 2 × 2.
  - Response: HI = 0xDEAD for 5 cycles, then HI = 0, LO = 4; two hilo_we pulses.
- MD_BYPASS_EN: mult 5 × 6 with mflo arriving at the final RUN cycle.
  - Response: no stall in that cycle; lo_rdata = 30 in the same cycle.
  - Without the macro: one extra stall cycle, and lo_rdata = 30 on the following cycle.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 33;
  localparam int DEF_CNT_W    = 6;

  function automatic logic [1:0] mdOpOf(input logic [2:0] opCode);
    case (opCode)
      OP_MULTU: return MD_MULTU;
      OP_DIV:   return MD_DIV;
      OP_DIVU:  return MD_DIVU;
      default:  return MD_MULT;
    endcase
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable down-counter that parks at zero; zero flags the final busy cycle.
module md_lat_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] loadVal,
  output logic [W-1:0] cnt,
  output logic         zero
);

  localparam logic [W-1:0] ONE = 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: launches the unit, counts its latency, owns HI/LO.
// Optional macro MD_BYPASS_EN forwards the unit result to mfhi/mflo in the final busy cycle.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        stall,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic        hilo_we,
  output logic        div_zero
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  logic [0:0]       state;
  logic [31:0]      hiQ;
  logic [31:0]      loQ;
  logic [CNT_W-1:0] cnt;
  logic             cntZero;
  logic             accept;
  logic             isMul;
  logic             isDiv;
  logic             isDivZero;
  logic             launch;
  logic             lastCycle;
  logic             commit;

  assign accept    = (state == ST_IDLE) && op_valid && !flush;
  assign isMul     = (op_code == OP_MULT) || (op_code == OP_MULTU);
  assign isDiv     = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign isDivZero = isDiv && (src_b == 32'd0);
  assign launch    = accept && (isMul || (isDiv && !isDivZero));
  assign lastCycle = (state == ST_RUN) && cntZero;
  // A flush in the final busy cycle still discards the unit's result.
  assign commit    = lastCycle && !flush;

  md_lat_cnt #(.W(CNT_W)) uCnt (
    .clk     (clk),
    .rst     (rst),
    .load    (launch),
    .clr     ((state == ST_RUN) && flush),
    .loadVal (isDiv ? DIV_LOAD : MULT_LOAD),
    .cnt     (cnt),
    .zero    (cntZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hiQ      <= '0;
      loQ      <= '0;
      md_start <= 1'b0;
      md_op    <= '0;
      md_a     <= '0;
      md_b     <= '0;
      hilo_we  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      md_start <= launch;
      div_zero <= accept && isDivZero;
      hilo_we  <= commit || (accept && ((op_code == OP_MTHI) || (op_code == OP_MTLO)));

      if (launch) begin
        md_a  <= src_a;
        md_b  <= src_b;
        md_op <= mdOpOf(op_code);
        state <= ST_RUN;
      end else if ((state == ST_RUN) && (flush || cntZero)) begin
        state <= ST_IDLE;
      end

      if (commit) begin
        hiQ <= md_hi;
        loQ <= md_lo;
      end else if (accept && (op_code == OP_MTHI)) begin
        hiQ <= src_a;
      end else if (accept && (op_code == OP_MTLO)) begin
        loQ <= src_a;
      end
    end
  end

`ifdef MD_BYPASS_EN
  assign stall    = (state == ST_RUN) && (op_valid || ((rd_hi || rd_lo) && !lastCycle));
  assign hi_rdata = lastCycle ? md_hi : hiQ;
  assign lo_rdata = lastCycle ? md_lo : loQ;
`else
  assign stall    = (state == ST_RUN) && (op_valid || rd_hi || rd_lo);
  assign hi_rdata = hiQ;
  assign lo_rdata = loQ;
`endif

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: hand-computed HI/LO results, stall counts and pulses.
module tb_md_sched;

  localparam logic [31:0] JUNK_HI = 32'hBAD0_0001;
  localparam logic [31:0] JUNK_LO = 32'hBAD0_0002;

`ifdef MD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        rd_hi;
  logic        rd_lo;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        stall;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;
  logic        hilo_we;
  logic        div_zero;

  int errors;
  int checks;
  int stallN;
  int weN;
  int weTotal;
  logic        lastStall;
  logic [31:0] lastHi;
  logic [31:0] lastLo;

  md_sched dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .rd_hi    (rd_hi),
    .rd_lo    (rd_lo),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_hi    (md_hi),
    .md_lo    (md_lo),
    .stall    (stall),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata),
    .hilo_we  (hilo_we),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accept edge; models the unit by presenting the
  // result only in the final busy cycle and junk before it.
  task automatic runBusy(input int lat, input logic [31:0] hiV, input logic [31:0] loV,
                         input logic rdLoLast, output int sN, output int wN,
                         output logic lStall, output logic [31:0] lHi, output logic [31:0] lLo);
    sN = 0;
    wN = 0;
    lStall = 1'b0;
    lHi = '0;
    lLo = '0;
    for (int k = 1; k <= lat; k++) begin
      md_hi = (k == lat) ? hiV : JUNK_HI;
      md_lo = (k == lat) ? loV : JUNK_LO;
      if ((k == lat) && rdLoLast) rd_lo = 1'b1;
      #1;
      sN = sN + int'(stall);
      wN = wN + int'(hilo_we);
      if (k == lat) begin
        lStall = stall;
        lHi = hi_rdata;
        lLo = lo_rdata;
      end
      tick();
    end
    md_hi = JUNK_HI;
    md_lo = JUNK_LO;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    op_valid = 1'b0;
    op_code = 3'b000;
    src_a = '0;
    src_b = '0;
    flush = 1'b0;
    rd_hi = 1'b0;
    rd_lo = 1'b0;
    md_hi = JUNK_HI;
    md_lo = JUNK_LO;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi_rdata, 32'd0);
    chk("rst_lo", lo_rdata, 32'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_start", md_start, 1'b0);
    chk("rst_we", hilo_we, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    chk("rst_op", md_op, 2'b00);
    chk("rst_a", md_a, 32'd0);
    chk("rst_b", md_b, 32'd0);
    rst = 1'b0;

    // Signed mult 7 * -3 with a dependent op held in EXE
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd7; src_b = 32'hFFFF_FFFD;
    #1;
    chk("mul_idle_stall", stall, 1'b0);
    tick();
    op_code = 3'b000;
    #1;
    chk("mul_start", md_start, 1'b1);
    chk("mul_a", md_a, 32'd7);
    chk("mul_b", md_b, 32'hFFFF_FFFD);
    chk("mul_op", md_op, 2'b00);
    runBusy(5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, stallN, weN, lastStall, lastHi, lastLo);
    chk("mul_stall_cycles", stallN, 32'd5);
    chk("mul_we_busy", weN, 32'd0);
    chk("mul_last_hi", lastHi, (BYP != 0) ? 32'hFFFF_FFFF : 32'd0);
    chk("mul_done_stall", stall, 1'b0);
    chk("mul_hi", hi_rdata, 32'hFFFF_FFFF);
    chk("mul_lo", lo_rdata, 32'hFFFF_FFEB);
    chk("mul_we", hilo_we, 1'b1);
    op_valid = 1'b0;
    tick();
    chk("mul_we_once", hilo_we, 1'b0);

    // divu 100 / 7 with mflo held in EXE
    op_valid = 1'b1; op_code = 3'b100; src_a = 32'd100; src_b = 32'd7;
    tick();
    op_valid = 1'b0; rd_lo = 1'b1;
    #1;
    chk("div_start", md_start, 1'b1);
    chk("div_op", md_op, 2'b11);
    chk("div_a", md_a, 32'd100);
    chk("div_b", md_b, 32'd7);
    runBusy(33, 32'd2, 32'd14, 1'b0, stallN, weN, lastStall, lastHi, lastLo);
    chk("div_stall_cycles", stallN, (BYP != 0) ? 32'd32 : 32'd33);
    chk("div_done_stall", stall, 1'b0);
    chk("div_lo", lo_rdata, 32'd14);
    chk("div_hi", hi_rdata, 32'd2);
    chk("div_we", hilo_we, 1'b1);
    rd_lo = 1'b0;

    // mthi 0x1234 then div by zero back to back
    op_valid = 1'b1; op_code = 3'b101; src_a = 32'h1234;
    tick();
    op_code = 3'b011; src_a = 32'd5; src_b = 32'd0;
    #1;
    chk("mthi_we", hilo_we, 1'b1);
    chk("mthi_hi", hi_rdata, 32'h1234);
    chk("dz_req_stall", stall, 1'b0);
    tick();
    op_valid = 1'b0; rd_hi = 1'b1;
    #1;
    chk("dz_pulse", div_zero, 1'b1);
    chk("dz_no_start", md_start, 1'b0);
    chk("dz_stall", stall, 1'b0);
    chk("dz_hi", hi_rdata, 32'h1234);
    chk("dz_we", hilo_we, 1'b0);
    tick();
    chk("dz_once", div_zero, 1'b0);
    chk("dz_no_start2", md_start, 1'b0);
    rd_hi = 1'b0;

    // mult 3 * 4 flushed in its second busy cycle
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd3; src_b = 32'd4;
    tick();
    op_valid = 1'b0;
    #1;
    chk("fl_start", md_start, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; rd_hi = 1'b1;
    #1;
    chk("fl_idle_stall", stall, 1'b0);
    chk("fl_we", hilo_we, 1'b0);
    rd_hi = 1'b0;
    weTotal = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      weTotal = weTotal + int'(hilo_we);
    end
    chk("fl_we_none", weTotal, 32'd0);
    chk("fl_hi", hi_rdata, 32'h1234);
    chk("fl_lo", lo_rdata, 32'd14);

    // mthi 0xDEAD immediately followed by mult 2 * 2
    op_valid = 1'b1; op_code = 3'b101; src_a = 32'hDEAD;
    tick();
    op_code = 3'b001; src_a = 32'd2; src_b = 32'd2;
    #1;
    weTotal = int'(hilo_we);
    chk("b2b_hi_dead", hi_rdata, 32'hDEAD);
    tick();
    op_valid = 1'b0;
    runBusy(5, 32'd0, 32'd4, 1'b0, stallN, weN, lastStall, lastHi, lastLo);
    weTotal = weTotal + weN + int'(hilo_we);
    chk("b2b_last_hi", lastHi, (BYP != 0) ? 32'd0 : 32'hDEAD);
    chk("b2b_hi", hi_rdata, 32'd0);
    chk("b2b_lo", lo_rdata, 32'd4);
    tick();
    weTotal = weTotal + int'(hilo_we);
    chk("b2b_we_pulses", weTotal, 32'd2);

    // mult 5 * 6 with mflo arriving in the final busy cycle
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd5; src_b = 32'd6;
    tick();
    op_valid = 1'b0;
    #1;
    chk("byp_a", md_a, 32'd5);
    runBusy(5, 32'd0, 32'd30, 1'b1, stallN, weN, lastStall, lastHi, lastLo);
    chk("byp_stall_cycles", stallN, (BYP != 0) ? 32'd0 : 32'd1);
    chk("byp_last_lo", lastLo, (BYP != 0) ? 32'd30 : 32'd4);
    chk("byp_next_stall", stall, 1'b0);
    chk("byp_next_lo", lo_rdata, 32'd30);
    rd_lo = 1'b0;

    // Op arriving in the commit cycle waits one cycle, then is accepted
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd1; src_b = 32'd1;
    tick();
    op_code = 3'b101; src_a = 32'h77;
    runBusy(5, 32'd0, 32'd1, 1'b0, stallN, weN, lastStall, lastHi, lastLo);
    chk("cc_stall_cycles", stallN, 32'd5);
    chk("cc_hi_commit", hi_rdata, 32'd0);
    chk("cc_lo_commit", lo_rdata, 32'd1);
    tick();
    op_valid = 1'b0;
    chk("cc_hi_mthi", hi_rdata, 32'h77);
    chk("cc_we", hilo_we, 1'b1);

    // Asynchronous reset in the middle of a busy period
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd9; src_b = 32'd9;
    tick();
    op_valid = 1'b0; rd_hi = 1'b1;
    #1;
    chk("rr_busy_stall", stall, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rr_stall", stall, 1'b0);
    chk("rr_hi", hi_rdata, 32'd0);
    chk("rr_lo", lo_rdata, 32'd0);
    chk("rr_start", md_start, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    chk("rr_idle_stall", stall, 1'b0);
    chk("rr_we", hilo_we, 1'b0);
    rd_hi = 1'b0;

    // mtlo
    op_valid = 1'b1; op_code = 3'b110; src_a = 32'hBEEF;
    tick();
    op_valid = 1'b0;
    chk("mtlo_lo", lo_rdata, 32'hBEEF);
    chk("mtlo_hi", hi_rdata, 32'd0);
    chk("mtlo_we", hilo_we, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
